// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sequencer around a 4-to-1 mux primitive (mux4_to_1).
// Steps the select pair {s1,s0} through channels 0..3, holding each select
// for SETTLE cycles and capturing mux_out in the last cycle of each window.
// It then presents the assembled 4-bit word through a valid/ready handshake.
//
// Ports:
//   clk     in   system clock, rising-edge active
//   rst     in   asynchronous active-high reset
//   start   in   scan request, sampled in IDLE (and at the HOLD handshake edge)
//   mux_out in   output of the mux4_to_1 instance
//   s0, s1  out  registered mux selects (LSB, MSB)
//   busy    out  high while scanning or holding an unconsumed word
//   word    out  snapshot, word[k] = mux_out captured while {s1,s0}=k
//   valid   out  word is available downstream
//   ready   in   downstream accept; handshake when valid && ready at an edge

module mux_scan_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mux_out,
    output logic       s0,
    output logic       s1,
    output logic       busy,
    output logic [3:0] word,
    output logic       valid,
    input  logic       ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [3:0] LAST = 4'(SETTLE - 1);

    state_t     state, state_nx;
    logic [1:0] idx, idx_nx;
    logic [3:0] cnt, cnt_nx;
    logic [2:0] shadow, shadow_nx;
    logic [3:0] word_nx;
    logic [1:0] sel, sel_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            cnt    <= '0;
            shadow <= '0;
            word   <= '0;
            sel    <= '0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            cnt    <= cnt_nx;
            shadow <= shadow_nx;
            word   <= word_nx;
            sel    <= sel_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        cnt_nx    = cnt;
        shadow_nx = shadow;
        word_nx   = word;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SCAN;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                end
            end
            SCAN: begin
                // cnt only counts 0..LAST, so != is equivalent to < here.
                if (cnt != LAST) begin
                    cnt_nx = cnt + 4'd1;
                end else begin
                    cnt_nx = '0;
                    if (idx == 2'd3) begin
                        word_nx  = {mux_out, shadow};
                        idx_nx   = '0;
                        state_nx = HOLD;
                    end else begin
                        // Channels arrive 0,1,2 in order; shifting in from the
                        // top leaves shadow = {ch2,ch1,ch0} after three captures,
                        // the same result as writing shadow[idx].
                        shadow_nx = {mux_out, shadow[2:1]};
                        idx_nx    = idx + 2'd1;
                    end
                end
            end
            HOLD: begin
                if (ready) begin
                    if (start) begin
                        state_nx = SCAN;
                        idx_nx   = '0;
                        cnt_nx   = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // Selects are registered from the next-state view so they track idx
        // during SCAN and park at 00 otherwise.
        sel_nx = (state_nx == SCAN) ? idx_nx : 2'b00;
    end

    assign s0    = sel[0];
    assign s1    = sel[1];
    assign busy  = (state == SCAN) || (state == HOLD);
    assign valid = (state == HOLD);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl. Two instances: SETTLE=1 and SETTLE=3.
// The mux4_to_1 behaviour is modelled inline; the SETTLE=3 path can inject a
// glitch on channel 1 early in its select window.

module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst;

    logic       start1, ready1, s0_1, s1_1, busy1, valid1, mux1;
    logic [3:0] word1, data1;

    logic       start3, ready3, s0_3, s1_3, busy3, valid3, mux3, glitch3;
    logic [3:0] word3, data3;

    logic [3:0] sb[$];
    int unsigned n_cmp;
    int unsigned n_err;

    assign mux1 = data1[{s1_1, s0_1}];
    assign mux3 = data3[{s1_3, s0_3}] ^ (glitch3 && ({s1_3, s0_3} == 2'd1));

    mux_scan_ctrl #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mux_out(mux1),
        .s0(s0_1), .s1(s1_1), .busy(busy1), .word(word1),
        .valid(valid1), .ready(ready1)
    );

    mux_scan_ctrl #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .mux_out(mux3),
        .s0(s0_3), .s1(s1_3), .busy(busy3), .word(word3),
        .valid(valid3), .ready(ready3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic [3:0] got);
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
        if (sb.size() != 0) check(tag, got, sb.pop_front());
    endtask

    task automatic wait_valid1(input int unsigned lim);
        int unsigned n;
        n = 0;
        while (!valid1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("valid1_seen", valid1, 1);
        if (valid1) pop_check("word1", word1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_err = 0;
        clk = 0; rst = 0;
        start1 = 0; ready1 = 0; data1 = '0;
        start3 = 0; ready3 = 0; data3 = '0; glitch3 = 0;

        // Asynchronous reset before any clock edge
        #1 rst = 1;
        #1;
        check("rst_sel1", {s1_1, s0_1}, 0);
        check("rst_busy1", busy1, 0);
        check("rst_valid1", valid1, 0);
        check("rst_word1", word1, 0);
        check("rst_dut3", {s1_3, s0_3, busy3, valid3, word3}, 0);
        repeat (3) @(negedge clk);
        check("rst_hold1", {s1_1, s0_1, busy1, valid1, word1}, 0);
        rst = 0;
        @(negedge clk);
        check("idle_nostart1", {busy1, valid1}, 0);

        // Basic scan, SETTLE=1, inputs 1010
        data1 = 4'b1010; start1 = 1; sb.push_back(4'b1010);
        @(negedge clk);
        start1 = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            check("t2_sel", {s1_1, s0_1}, k);
            check("t2_busy", busy1, 1);
            check("t2_valid_lo", valid1, 0);
        end
        @(negedge clk);
        check("t2_valid", valid1, 1);
        check("t2_busy_hold", busy1, 1);
        check("t2_sel_hold", {s1_1, s0_1}, 0);
        pop_check("t2_word", word1);

        // Backpressure: inputs change, word must not
        data1 = 4'b0101;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_word", word1, 4'b1010);
            check("bp_valid", valid1, 1);
        end
        ready1 = 1;
        @(negedge clk);
        ready1 = 0;
        check("bp_valid_drop", valid1, 0);
        check("bp_busy_drop", busy1, 0);
        check("bp_sel", {s1_1, s0_1}, 0);
        check("bp_word_kept", word1, 4'b1010);
        @(negedge clk);
        ready1 = 1;
        @(negedge clk);
        ready1 = 0;
        check("ready_idle_noeffect", {busy1, valid1}, 0);

        // start held during SCAN is ignored
        data1 = 4'b0011; start1 = 1; sb.push_back(4'b0011);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        start1 = 0;
        wait_valid1(8);
        ready1 = 1;
        @(negedge clk);
        ready1 = 0;
        check("t5a_valid_drop", valid1, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t5a_no_requeue", busy1, 0);
        end

        // start + ready on the handshake edge restarts immediately
        data1 = 4'b1001; start1 = 1; sb.push_back(4'b1001);
        @(negedge clk);
        start1 = 0;
        wait_valid1(8);
        data1 = 4'b1100; sb.push_back(4'b1100);
        start1 = 1; ready1 = 1;
        @(negedge clk);
        start1 = 0; ready1 = 0;
        check("t5b_valid_drop", valid1, 0);
        check("t5b_busy", busy1, 1);
        check("t5b_sel", {s1_1, s0_1}, 0);
        wait_valid1(8);
        ready1 = 1;
        @(negedge clk);
        ready1 = 0;

        // SETTLE=3 with a glitch early in channel 1's window
        data3 = 4'b0110; start3 = 1; sb.push_back(4'b0110);
        @(negedge clk);
        start3 = 0;
        for (int j = 0; j < 12; j++) begin
            if (j > 0) @(negedge clk);
            glitch3 = (j == 3) || (j == 4);
            check("t4_sel", {s1_3, s0_3}, j / 3);
            check("t4_valid_lo", valid3, 0);
        end
        glitch3 = 0;
        @(negedge clk);
        check("t4_valid", valid3, 1);
        pop_check("t4_word", word3);
        ready3 = 1;
        @(negedge clk);
        ready3 = 0;
        check("t4_valid_drop", valid3, 0);

        // Reset mid-scan at idx=2
        data1 = 4'b1111; start1 = 1;
        @(negedge clk);
        start1 = 0;
        @(negedge clk);
        @(negedge clk);
        check("t6_sel_idx2", {s1_1, s0_1}, 2);
        #1 rst = 1;
        #1;
        check("t6_async_clear", {s1_1, s0_1, busy1, valid1}, 0);
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t6_no_valid", {busy1, valid1}, 0);
        end
        data1 = 4'b0001; start1 = 1; sb.push_back(4'b0001);
        @(negedge clk);
        start1 = 0;
        repeat (3) @(negedge clk);
        check("t6_valid_lo", valid1, 0);
        @(negedge clk);
        check("t6_valid", valid1, 1);
        pop_check("t6_word", word1);
        ready1 = 1;
        @(negedge clk);
        ready1 = 0;
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
